slc3_script_sequencer: RTL and testbench
========================================

SLC3_SCRIPT_SEQUENCER -- requirements
Module: slc3_script_sequencer

Interface
REQ-001 SHALL have parameter SW_W, default 10, switch bus width.
REQ-002 SHALL have parameter LED_W, default 10, LED bus width.
REQ-003 SHALL have parameter DEPTH, default 8, script entries (power of two, >=2); AW = clog2(DEPTH).
REQ-004 SHALL have parameter PULSE_LEN, default 2, cycles a button is held low.
REQ-005 SHALL have parameter SETTLE_LEN, default 5, cycles waited after each step action.
REQ-006 SHALL have parameter TIMEOUT, default 65535, maximum WAIT cycles per step.
REQ-007 SHALL have port Clk, input, 1, sole clock; all logic on its rising edge.
REQ-008 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port start, input, 1, one-cycle request to run the script.
REQ-010 SHALL have port prog_we, input, 1, script write strobe.
REQ-011 SHALL have port prog_addr, input, AW, script write index.
REQ-012 SHALL have port prog_data, input, 18+SW_W, entry {cond[1:0], match[15:0], sw_val[SW_W-1:0]}.
REQ-013 SHALL have port ADDR, input, 16, CPU address bus being observed.
REQ-014 SHALL have port LED, input, LED_W, CPU LED bus being observed.
REQ-015 SHALL have port SW, output, SW_W, switch value presented to the CPU.
REQ-016 SHALL have port Run, output, 1, active-low Run button.
REQ-017 SHALL have port Continue, output, 1, active-low Continue button.
REQ-018 SHALL have port busy, output, 1, high in every state except IDLE, DONE and ERROR.
REQ-019 SHALL have port done, output, 1, high while in DONE.
REQ-020 SHALL have port timeout_err, output, 1, high while in ERROR.
REQ-021 SHALL have port step_idx, output, AW, index of the current entry.

Function
REQ-022 SHALL decode cond as: 0 = ADDR==match; 1 = LED==match[LED_W-1:0]; 2 = unconditional; 3 = end of script.
REQ-023 SHALL write prog_data into entry prog_addr on prog_we only when busy=0; writes while busy SHALL be ignored.
REQ-024 SHALL implement states IDLE, RST_PULSE, RST_GAP, RUN_PULSE, WAIT, CONT_PULSE, SETTLE, DONE, ERROR.
REQ-025 SHALL leave IDLE, DONE or ERROR on start=1, go to RST_PULSE and set step_idx=0; start while busy SHALL be ignored.
REQ-026 SHALL drive Run=0 and Continue=0 for PULSE_LEN cycles in RST_PULSE, then move to RST_GAP.
REQ-027 SHALL drive both buttons high for PULSE_LEN cycles in RST_GAP, then move to RUN_PULSE.
REQ-028 SHALL drive Run=0 for PULSE_LEN cycles in RUN_PULSE, then move to WAIT.
REQ-029 SHALL evaluate the entry at step_idx in WAIT every cycle; cond 3 SHALL go to DONE the next cycle.
REQ-030 SHALL, on a met cond 0 or 2, load SW<=sw_val and go to SETTLE.
REQ-031 SHALL, on a met cond 1, load SW<=sw_val and go to CONT_PULSE, driving Continue=0 for PULSE_LEN cycles, then go to SETTLE.
REQ-032 SHALL hold in SETTLE for SETTLE_LEN cycles, then increment step_idx and return to WAIT.
REQ-033 SHALL go to DONE instead of WAIT when SETTLE ends with step_idx=DEPTH-1; step_idx SHALL never wrap.
REQ-034 SHALL count WAIT cycles per step, clear the count on entering WAIT, and go to ERROR when the count reaches TIMEOUT with the condition unmet.
REQ-035 SHALL give a met condition priority over timeout when both occur in the same cycle.
REQ-036 SHALL hold SW between steps; SW changes only in the WAIT->action transition.
REQ-037 SHALL register all outputs with no combinational input-to-output path; button outputs SHALL be glitch-free.

Reset
REQ-038 SHALL, on Reset=1 at a clock edge, enter IDLE, set SW=0, Run=1, Continue=1, busy=0, done=0, timeout_err=0, step_idx=0 and clear all counters, mid-sequence included.
REQ-039 SHALL NOT clear script contents on reset.
REQ-040 SHALL give Reset priority over start and prog_we in the same cycle.

Verification
REQ-041 SHALL be checked: start -> Run and Continue low 2 cycles, both high 2 cycles, Run low 2 cycles, busy=1.
REQ-042 SHALL be checked: entry0 {0,FFFF,003}, entry1 {3}, ADDR=FFFF at cycle 20 -> SW=003 next cycle, done=1 after 5 settle cycles plus 1 cycle.
REQ-043 SHALL be checked: entry {1,0001,38A} with LED=001 -> SW=38A, Continue low exactly 2 cycles, then step_idx increments after 5 cycles.
REQ-044 SHALL be checked: TIMEOUT=16 with an unmet cond 0 -> timeout_err=1 after 16 WAIT cycles, buttons high, busy=0.
REQ-045 SHALL be checked: Reset asserted during CONT_PULSE -> next cycle Continue=1, SW=0, IDLE; a new start replays the unchanged script.
REQ-046 SHALL be checked: eight cond-2 entries -> done after step 7, step_idx=7, with no wrap to 0.

Source files
------------

// File: rtl/slc3_script_sequencer.sv
// Scripted stimulus driver for an SLC-3 board: pulses Run/Continue and walks a
// small program of {cond, match, sw_val} entries against the observed ADDR/LED buses.
module slc3_script_sequencer #(
  parameter  int SW_W       = 10,
  parameter  int LED_W      = 10,
  parameter  int DEPTH      = 8,
  parameter  int PULSE_LEN  = 2,
  parameter  int SETTLE_LEN = 5,
  parameter  int TIMEOUT    = 65535,
  localparam int AW         = $clog2(DEPTH),
  localparam int EW         = 18 + SW_W
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start,
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [EW-1:0]   prog_data,
  input  logic [15:0]     ADDR,
  input  logic [LED_W-1:0] LED,
  output logic [SW_W-1:0] SW,
  output logic            Run,
  output logic            Continue,
  output logic            busy,
  output logic            done,
  output logic            timeout_err,
  output logic [AW-1:0]   step_idx
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_PULSE, S_RST_GAP, S_RUN_PULSE, S_WAIT,
    S_CONT_PULSE, S_SETTLE, S_DONE, S_ERROR
  } state_t;

  localparam int CMAX = (PULSE_LEN > SETTLE_LEN) ? PULSE_LEN : SETTLE_LEN;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] PL_END = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] SL_END = CW'(SETTLE_LEN - 1);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [TW-1:0]   wcnt, wcnt_n;
  logic [AW-1:0]   idx_n;
  logic [SW_W-1:0] sw_n;

  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   entry;
  logic [1:0]      cond;
  logic [15:0]     match;
  logic [SW_W-1:0] sw_val;
  logic            met;

  // Script store; contents survive reset and are frozen while a run is active.
  always_ff @(posedge Clk) begin
    if (!Reset && prog_we && !busy) mem[prog_addr] <= prog_data;
  end

  assign entry  = mem[step_idx];
  assign cond   = entry[EW-1 -: 2];
  assign match  = entry[SW_W +: 16];
  assign sw_val = entry[SW_W-1:0];

  always_comb begin
    met = 1'b0;
    case (cond)
      2'd0:    met = (ADDR == match);
      2'd1:    met = (LED == match[LED_W-1:0]);
      2'd2:    met = 1'b1;
      default: met = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wcnt_n  = wcnt;
    idx_n   = step_idx;
    sw_n    = SW;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_n = S_RST_PULSE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      S_RST_PULSE: begin
        if (cnt == PL_END) begin state_n = S_RST_GAP; cnt_n = '0; end
        else cnt_n = cnt + 1'b1;
      end
      S_RST_GAP: begin
        if (cnt == PL_END) begin state_n = S_RUN_PULSE; cnt_n = '0; end
        else cnt_n = cnt + 1'b1;
      end
      S_RUN_PULSE: begin
        if (cnt == PL_END) begin state_n = S_WAIT; cnt_n = '0; wcnt_n = '0; end
        else cnt_n = cnt + 1'b1;
      end
      S_WAIT: begin
        // A met condition wins over a timeout landing on the same cycle.
        if (cond == 2'd3) state_n = S_DONE;
        else if (met) begin
          sw_n    = sw_val;
          cnt_n   = '0;
          state_n = (cond == 2'd1) ? S_CONT_PULSE : S_SETTLE;
        end
        else if (wcnt == TO_END) state_n = S_ERROR;
        else wcnt_n = wcnt + 1'b1;
      end
      S_CONT_PULSE: begin
        if (cnt == PL_END) begin state_n = S_SETTLE; cnt_n = '0; end
        else cnt_n = cnt + 1'b1;
      end
      S_SETTLE: begin
        if (cnt == SL_END) begin
          cnt_n = '0;
          if (step_idx == LAST) state_n = S_DONE;
          else begin
            idx_n   = step_idx + 1'b1;
            wcnt_n  = '0;
            state_n = S_WAIT;
          end
        end
        else cnt_n = cnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so buttons never glitch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wcnt        <= '0;
      step_idx    <= '0;
      SW          <= '0;
      Run         <= 1'b1;
      Continue    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      wcnt        <= wcnt_n;
      step_idx    <= idx_n;
      SW          <= sw_n;
      Run         <= !(state_n == S_RST_PULSE || state_n == S_RUN_PULSE);
      Continue    <= !(state_n == S_RST_PULSE || state_n == S_CONT_PULSE);
      busy        <= !(state_n == S_IDLE || state_n == S_DONE || state_n == S_ERROR);
      done        <= (state_n == S_DONE);
      timeout_err <= (state_n == S_ERROR);
    end
  end

endmodule

// File: tb/tb_slc3_script_sequencer.sv
// Bench for slc3_script_sequencer: a procedural timeline model of the script run
// is compared every cycle, plus directed literal checks at hand-counted cycles.
module tb_slc3_script_sequencer;
  localparam int SW_W = 10, LED_W = 10, DEPTH = 8, AW = 3, EW = 28;
  localparam int PL = 2, SL = 5, TO = 16;

  logic Clk = 1'b0;
  logic Reset, start, prog_we;
  logic [AW-1:0] prog_addr;
  logic [EW-1:0] prog_data;
  logic [15:0] ADDR;
  logic [LED_W-1:0] LED;
  logic [SW_W-1:0] SW;
  logic Run, Continue, busy, done, timeout_err;
  logic [AW-1:0] step_idx;

  int nchk = 0, nerr = 0;
  bit chk_en = 0;

  slc3_script_sequencer #(.SW_W(SW_W), .LED_W(LED_W), .DEPTH(DEPTH), .PULSE_LEN(PL),
                          .SETTLE_LEN(SL), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .ADDR(ADDR), .LED(LED), .SW(SW), .Run(Run), .Continue(Continue),
    .busy(busy), .done(done), .timeout_err(timeout_err), .step_idx(step_idx));

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [SW_W-1:0] m_sw = '0;
  bit m_run = 1, m_cont = 1, m_busy = 0, m_done = 0, m_err = 0;
  int m_idx = 0;
  logic [EW-1:0] m_mem [DEPTH];

  task automatic edge_(output bit a);
    @(posedge Clk);
    a = Reset;
    if (Reset) begin
      m_sw = '0; m_run = 1; m_cont = 1; m_busy = 0; m_done = 0; m_err = 0; m_idx = 0;
    end else if (prog_we && !m_busy) m_mem[prog_addr] = prog_data;
  endtask

  task automatic hold(input int n, output bit a);
    a = 0;
    repeat (n) begin edge_(a); if (a) return; end
  endtask

  task automatic run_script();
    bit a, met;
    int waited;
    logic [EW-1:0] e;
    m_busy = 1; m_done = 0; m_err = 0; m_idx = 0; m_run = 0; m_cont = 0;
    hold(PL-1, a); if (a) return;
    edge_(a); if (a) return;
    m_run = 1; m_cont = 1;
    hold(PL-1, a); if (a) return;
    edge_(a); if (a) return;
    m_run = 0;
    hold(PL-1, a); if (a) return;
    edge_(a); if (a) return;
    m_run = 1;
    forever begin
      waited = 0;
      forever begin
        edge_(a); if (a) return;
        e = m_mem[m_idx];
        if (e[27:26] == 2'd3) begin m_busy = 0; m_done = 1; return; end
        met = (e[27:26] == 2'd2) || (e[27:26] == 2'd0 && ADDR == e[25:10]) ||
              (e[27:26] == 2'd1 && LED == e[19:10]);
        if (met) break;
        waited++;
        if (waited == TO) begin m_busy = 0; m_err = 1; return; end
      end
      m_sw = e[9:0];
      if (e[27:26] == 2'd1) begin
        m_cont = 0;
        hold(PL-1, a); if (a) return;
        edge_(a); if (a) return;
        m_cont = 1;
      end
      hold(SL-1, a); if (a) return;
      edge_(a); if (a) return;
      if (m_idx == DEPTH-1) begin m_busy = 0; m_done = 1; return; end
      m_idx++;
    end
  endtask

  initial begin : model
    bit a;
    forever begin
      do edge_(a); while (a || !start);
      run_script();
    end
  end

  initial begin : compare
    forever begin
      @(posedge Clk); #2;
      if (chk_en) begin
        check("mdl_sw", SW, m_sw);
        check("mdl_run", Run, m_run);
        check("mdl_cont", Continue, m_cont);
        check("mdl_busy", busy, m_busy);
        check("mdl_done", done, m_done);
        check("mdl_err", timeout_err, m_err);
        check("mdl_idx", step_idx, m_idx);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic prog(input int a, input logic [1:0] c, input logic [15:0] m,
                      input logic [SW_W-1:0] s);
    prog_addr = AW'(a); prog_data = {c, m, s}; prog_we = 1;
    @(negedge Clk);
    prog_we = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge Clk);
    start = 0;
  endtask

  initial begin : stim
    logic [0:6] runseq, contseq;
    runseq = 7'b0011001; contseq = 7'b0011111;
    Reset = 1; start = 0; prog_we = 0; prog_addr = '0; prog_data = '0; ADDR = '0; LED = '0;
    @(negedge Clk);
    chk_en = 1;
    @(negedge Clk);
    check("rst_sw", SW, 0); check("rst_run", Run, 1); check("rst_cont", Continue, 1);
    check("rst_busy", busy, 0); check("rst_idx", step_idx, 0);
    Reset = 0;
    @(negedge Clk);

    // Match on ADDR at cycle 20, then end-of-script.
    prog(0, 2'd0, 16'hFFFF, 10'h003);
    prog(1, 2'd3, 16'h0000, 10'h000);
    pulse_start();
    for (int k = 0; k < 7; k++) begin
      check("seq_run", Run, runseq[k]);
      check("seq_cont", Continue, contseq[k]);
      check("seq_busy", busy, 1);
      if (k < 6) @(negedge Clk);
    end
    repeat (13) @(negedge Clk);
    ADDR = 16'hFFFF;
    @(negedge Clk);
    check("a_sw", SW, 10'h003);
    ADDR = 16'h0000;
    repeat (5) @(negedge Clk);
    check("a_idx", step_idx, 1); check("a_done_early", done, 0);
    @(negedge Clk);
    check("a_done", done, 1); check("a_busy", busy, 0);

    // LED match with Continue pulse.
    prog(0, 2'd1, 16'h0001, 10'h38A);
    LED = 10'h001;
    pulse_start();
    repeat (7) @(negedge Clk);
    check("b_sw", SW, 10'h38A); check("b_cont0", Continue, 0); check("b_run", Run, 1);
    @(negedge Clk); check("b_cont1", Continue, 0);
    @(negedge Clk); check("b_cont2", Continue, 1);
    repeat (4) @(negedge Clk); check("b_idx0", step_idx, 0);
    @(negedge Clk); check("b_idx1", step_idx, 1);
    @(negedge Clk); check("b_done", done, 1);

    // Reset in CONT_PULSE beats start and prog_we; script replays unchanged.
    pulse_start();
    repeat (7) @(negedge Clk);
    check("c_cont_pre", Continue, 0);
    Reset = 1; start = 1; prog_addr = '0; prog_data = {2'd2, 16'h0000, 10'h155}; prog_we = 1;
    @(negedge Clk);
    Reset = 0; start = 0; prog_we = 0;
    check("c_cont", Continue, 1); check("c_sw", SW, 0); check("c_busy", busy, 0);
    check("c_idx", step_idx, 0);
    @(negedge Clk);
    pulse_start();
    repeat (7) @(negedge Clk);
    check("c_replay_sw", SW, 10'h38A);
    repeat (8) @(negedge Clk);
    check("c_replay_done", done, 1);

    // Timeout on unmet ADDR; write while busy must be ignored.
    prog(0, 2'd0, 16'h1234, 10'h0AA);
    ADDR = 16'h0000;
    pulse_start();
    prog(0, 2'd2, 16'h0000, 10'h3FF);
    repeat (20) @(negedge Clk);
    check("d_err_early", timeout_err, 0); check("d_busy_early", busy, 1);
    @(negedge Clk);
    check("d_err", timeout_err, 1); check("d_busy", busy, 0);
    check("d_run", Run, 1); check("d_cont", Continue, 1); check("d_sw_held", SW, 10'h38A);

    // Match on the final WAIT cycle wins over timeout.
    pulse_start();
    repeat (21) @(negedge Clk);
    ADDR = 16'h1234;
    @(negedge Clk);
    ADDR = 16'h0000;
    check("d2_sw", SW, 10'h0AA); check("d2_err", timeout_err, 0); check("d2_busy", busy, 1);
    repeat (6) @(negedge Clk);
    check("d2_done", done, 1);

    // Eight unconditional steps: ends at idx 7 without wrapping; mid-run start ignored.
    for (int i = 0; i < DEPTH; i++) prog(i, 2'd2, 16'h0000, SW_W'(i + 1));
    pulse_start();
    repeat (10) @(negedge Clk);
    pulse_start();
    repeat (42) @(negedge Clk);
    check("e_idx_pre", step_idx, 7); check("e_done_pre", done, 0);
    @(negedge Clk);
    check("e_done", done, 1); check("e_idx", step_idx, 7); check("e_sw", SW, 10'h008);
    repeat (3) @(negedge Clk);
    check("e_idx_hold", step_idx, 7); check("e_done_hold", done, 1);
    pulse_start();
    check("e_restart_busy", busy, 1); check("e_restart_idx", step_idx, 0);
    repeat (10) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
